product_accumulator: RTL and testbench

- Downstream consumer of the 16-bit multiplier result in the arithmetic test chain.
- Accepts COUNT unsigned products over a valid/ready handshake, sums them into an ACC_W-bit accumulator, and presents one frame sum with an overflow flag.
- Holds each result until the sink accepts it, so the sink can apply backpressure.
- First clocked stage of the chain; gives the property suite real sequential behaviour to check.

---
 rtl/product_accumulator.sv | 96 +++++++++
 tb/tb_product_accumulator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Frame accumulator: sums COUNT unsigned products, then holds the sum and overflow flag until the sink takes them.
// Build option: define PRODUCT_ACC_SATURATE_EN to clamp the sum at 2^ACC_W-1 instead of wrapping.
module product_accumulator #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 24,
   parameter int COUNT  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_overflow
);
   localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t           state_reg;
   logic [ACC_W-1:0] acc_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             sticky_reg;

   logic [ACC_W:0]   sum_ext;
   logic             carry;
   logic [ACC_W-1:0] acc_next;
   logic             accept;
   logic             transfer;

   assign accept   = in_valid && in_ready;
   assign transfer = out_valid && out_ready;
   assign sum_ext  = {1'b0, acc_reg} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
   assign carry    = sum_ext[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
   // Once clamped, the accumulator stays at full scale for the rest of the frame.
   assign acc_next = (carry || sticky_reg) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
   assign acc_next = sum_ext[ACC_W-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ACCUM;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         sticky_reg   <= 1'b0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_overflow <= 1'b0;
      end else if (flush) begin
         // Abort wins over accept and transfer; any pending result is dropped.
         state_reg  <= ACCUM;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         sticky_reg <= 1'b0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
      end else begin
         case (state_reg)
            ACCUM: begin
               if (accept) begin
                  if (cnt_reg == LAST) begin
                     out_sum      <= acc_next;
                     out_overflow <= sticky_reg | carry;
                     state_reg    <= HOLD;
                     in_ready     <= 1'b0;
                     out_valid    <= 1'b1;
                  end else begin
                     acc_reg    <= acc_next;
                     cnt_reg    <= cnt_reg + CNT_W'(1);
                     sticky_reg <= sticky_reg | carry;
                  end
               end
            end
            HOLD: begin
               if (transfer) begin
                  acc_reg    <= '0;
                  cnt_reg    <= '0;
                  sticky_reg <= 1'b0;
                  state_reg  <= ACCUM;
                  in_ready   <= 1'b1;
                  out_valid  <= 1'b0;
               end
            end
            default: state_reg <= ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three configurations (defaults, ACC_W=17, COUNT=1) against a frame-level model.
module tb_product_accumulator;
   localparam int N = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0] in_valid, in_ready, flush, out_valid, out_ready, out_overflow;
   logic [15:0]  in_data [N];
   logic [23:0]  out_sum0;
   logic [16:0]  out_sum1;
   logic [23:0]  out_sum2;

   product_accumulator u_def (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .flush(flush[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(out_sum0),
      .out_overflow(out_overflow[0]));

   product_accumulator #(.ACC_W(17)) u_ovf (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .flush(flush[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(out_sum1),
      .out_overflow(out_overflow[1]));

   product_accumulator #(.COUNT(1)) u_one (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
      .flush(flush[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(out_sum2),
      .out_overflow(out_overflow[2]));

`ifdef PRODUCT_ACC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   int acc_w [N] = '{24, 17, 24};
   int cnt_n [N] = '{4, 4, 1};

   // Frame-level model: running total of accepted products, result fixed when the frame completes.
   bit     hold_m  [N];
   longint total_m [N];
   int     n_m     [N];
   longint sum_m   [N];
   bit     ovf_m   [N];

   int checks = 0;
   int errors = 0;
   longint dut_q [$];

   function automatic longint dut_sum(int k);
      case (k)
         0:       return longint'(out_sum0);
         1:       return longint'(out_sum1);
         default: return longint'(out_sum2);
      endcase
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < N; k++) begin
         if (rst || flush[k] || (hold_m[k] && out_ready[k])) begin
            hold_m[k]  = 1'b0;
            total_m[k] = 0;
            n_m[k]     = 0;
            if (rst) begin
               sum_m[k] = 0;
               ovf_m[k] = 1'b0;
            end
         end else if (!hold_m[k] && in_valid[k]) begin
            longint full;
            full       = longint'(1) << acc_w[k];
            total_m[k] += longint'(in_data[k]);
            n_m[k]++;
            if (n_m[k] == cnt_n[k]) begin
               hold_m[k] = 1'b1;
               ovf_m[k]  = (total_m[k] >= full);
               sum_m[k]  = (SAT && ovf_m[k]) ? full - 1 : total_m[k] % full;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("in_ready%0d", k), in_ready[k], !hold_m[k]);
         chk($sformatf("out_valid%0d", k), out_valid[k], hold_m[k]);
         if (hold_m[k]) begin
            chk($sformatf("out_sum%0d", k), dut_sum(k), sum_m[k]);
            chk($sformatf("out_overflow%0d", k), out_overflow[k], ovf_m[k]);
         end
      end
      if (!rst && out_valid[2] && out_ready[2] && !flush[2]) dut_q.push_back(dut_sum(2));
   end

   initial begin
      in_valid  = '0;
      flush     = '0;
      out_ready = '1;
      for (int k = 0; k < N; k++) in_data[k] = '0;
      repeat (2) step();
      chk("reset_in_ready", in_ready[0], 1);
      chk("reset_out_valid", out_valid[0], 0);
      chk("reset_out_sum", out_sum0, 0);
      chk("reset_out_overflow", out_overflow[0], 0);
      rst = 1'b0;
      step();
      chk("release_in_ready", in_ready[0], 1);

      // Basic frame on the default instance, overflow frame on ACC_W=17 in parallel.
      for (int i = 0; i < 4; i++) begin
         in_valid[0] = 1'b1; in_data[0] = 16'(10 * (i + 1));
         in_valid[1] = 1'b1; in_data[1] = 16'hFFFF;
         if (i == 3) chk("basic_not_early", out_valid[0], 0);
         step();
      end
      in_valid = '0;
      chk("basic_valid", out_valid[0], 1);
      chk("basic_sum", out_sum0, 100);
      chk("basic_ovf", out_overflow[0], 0);
      chk("basic_in_ready_low", in_ready[0], 0);
      chk("ovf_sum", out_sum1, SAT ? 64'h1FFFF : 64'h1FFFC);
      chk("ovf_flag", out_overflow[1], 1);
      chk("model_ovf_sum", sum_m[1], SAT ? 64'h1FFFF : 64'h1FFFC);
      step();
      chk("basic_in_ready_back", in_ready[0], 1);
      chk("basic_valid_gone", out_valid[0], 0);

      // Backpressure with in_valid held high while holding.
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1; in_data[0] = 16'd1;
      repeat (4) step();
      repeat (5) begin
         step();
         chk("bp_in_ready", in_ready[0], 0);
         chk("bp_sum", out_sum0, 4);
      end
      in_valid[0] = 1'b0; out_ready[0] = 1'b1;
      step();
      chk("bp_released_valid", out_valid[0], 0);
      chk("bp_released_ready", in_ready[0], 1);

      // Flush mid-frame drops the product presented with it.
      foreach (dut_q[i]) ;
      in_valid[0] = 1'b1; in_data[0] = 16'd7; step();
      in_data[0] = 16'd9; step();
      flush[0] = 1'b1; in_data[0] = 16'd100; step();
      flush[0] = 1'b0;
      for (int i = 1; i <= 4; i++) begin in_data[0] = 16'(i); step(); end
      in_valid[0] = 1'b0;
      chk("flush_sum", out_sum0, 10);
      chk("model_flush_sum", sum_m[0], 10);
      step();

      // Flush while holding discards the result.
      out_ready[0] = 1'b0;
      in_valid[0] = 1'b1; in_data[0] = 16'd2;
      repeat (4) step();
      in_valid[0] = 1'b0;
      chk("hold_before_flush", out_valid[0], 1);
      flush[0] = 1'b1; step(); flush[0] = 1'b0;
      chk("flush_hold_valid", out_valid[0], 0);
      chk("flush_hold_ready", in_ready[0], 1);

      // Asynchronous reset while holding.
      in_valid[0] = 1'b1; in_data[0] = 16'd1;
      repeat (4) step();
      in_valid[0] = 1'b0;
      chk("areset_pre_valid", out_valid[0], 1);
      #2 rst = 1'b1;
      #1;
      chk("areset_valid", out_valid[0], 0);
      chk("areset_sum", out_sum0, 0);
      chk("areset_ready", in_ready[0], 1);
      @(posedge clk); #1 rst = 1'b0;
      out_ready[0] = 1'b1;
      chk("areset_release_ready", in_ready[0], 1);
      in_valid[0] = 1'b1; in_data[0] = 16'd5;
      repeat (4) step();
      in_valid[0] = 1'b0;
      chk("areset_frame_sum", out_sum0, 20);
      step();

      // COUNT=1 throughput: data advances only when accepted.
      dut_q.delete();
      in_valid[2] = 1'b1; in_data[2] = 16'd3;
      for (int i = 0; i < 12; i++) begin
         logic r;
         r = in_ready[2];
         step();
         if (r) in_data[2] = in_data[2] + 16'd1;
      end
      in_valid[2] = 1'b0;
      chk("thr_count", dut_q.size(), 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("thr_result%0d", i), (i < dut_q.size()) ? dut_q[i] : -1, 3 + i);
      step();

      // Randomized traffic on all three instances.
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++) begin
            in_valid[k]  = ($urandom_range(0, 3) != 0);
            out_ready[k] = ($urandom_range(0, 2) != 0);
            flush[k]     = ($urandom_range(0, 29) == 0);
            in_data[k]   = (k == 1 || $urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
         end
         step();
      end
      in_valid = '0; flush = '0; out_ready = '1;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
